// File: rtl/md_stall_ctrl.sv
// Pipeline stall/sequencing controller: HI/LO busy countdown, hazard merge,
// per-stage register enables and a stall-cycle performance counter.
module md_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        freeze,
  input  logic        D_dataHazard,
  input  logic        D_mdUse,
  input  logic        E_mdStart,
  input  logic        E_mdIsDiv,
  output logic        F_pcEn,
  output logic        D_regEn,
  output logic        E_regEn,
  output logic        E_flush,
  output logic        M_regEn,
  output logic        W_regEn,
  output logic        E_mdBusy,
  output logic        E_mdDone,
  output logic        mdOverlapErr,
  output logic [31:0] stallCnt
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;

  logic busy;
  logic last;
  logic stall;

  assign busy  = (state_q == ST_BUSY);
  assign last  = busy && (cnt_q == CNT_ONE);
  // A start in E blocks an MD-use in D in the same cycle, before busy rises.
  assign stall = D_dataHazard | (D_mdUse & (E_mdStart | busy));

  always_comb begin
    F_pcEn   = 1'b1;
    D_regEn  = 1'b1;
    E_regEn  = 1'b1;
    M_regEn  = 1'b1;
    W_regEn  = 1'b1;
    E_flush  = 1'b0;
    E_mdBusy = 1'b0;
    E_mdDone = 1'b0;
    if (!reset) begin
      E_mdBusy = busy;
      if (freeze) begin
        F_pcEn  = 1'b0;
        D_regEn = 1'b0;
        E_regEn = 1'b0;
        M_regEn = 1'b0;
        W_regEn = 1'b0;
      end else begin
        F_pcEn   = !stall;
        D_regEn  = !stall;
        E_flush  = stall;
        E_mdDone = last;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    stall_cnt_d = stall_cnt_q;
    if (!freeze) begin
      if (stall)
        stall_cnt_d = stall_cnt_q + 32'd1;
      if (busy) begin
        // A start while busy is dropped; the running countdown wins.
        if (E_mdStart)
          err_d = 1'b1;
        cnt_d = cnt_q - CNT_ONE;
        if (last)
          state_d = ST_IDLE;
      end else if (E_mdStart) begin
        state_d = ST_BUSY;
        cnt_d   = E_mdIsDiv ? DIV_LD : MULT_LD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mdOverlapErr = err_q;
  assign stallCnt     = stall_cnt_q;

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Directed bench for md_stall_ctrl with a cycle-level model of the stall rules.
module tb_md_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset, freeze, D_dataHazard, D_mdUse, E_mdStart, E_mdIsDiv;
  logic        F_pcEn, D_regEn, E_regEn, E_flush, M_regEn, W_regEn;
  logic        E_mdBusy, E_mdDone, mdOverlapErr;
  logic [31:0] stallCnt;

  md_stall_ctrl dut (
    .clk(clk), .reset(reset), .freeze(freeze), .D_dataHazard(D_dataHazard),
    .D_mdUse(D_mdUse), .E_mdStart(E_mdStart), .E_mdIsDiv(E_mdIsDiv),
    .F_pcEn(F_pcEn), .D_regEn(D_regEn), .E_regEn(E_regEn), .E_flush(E_flush),
    .M_regEn(M_regEn), .W_regEn(W_regEn), .E_mdBusy(E_mdBusy),
    .E_mdDone(E_mdDone), .mdOverlapErr(mdOverlapErr), .stallCnt(stallCnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: remaining busy cycles of the current HI/LO operation (0 = free).
  int          m_rem = 0;
  logic        m_err = 1'b0;
  logic [31:0] m_cnt = 32'd0;

  // Running tallies of what the DUT showed; the main flow takes deltas.
  int busy_seen = 0;
  int done_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_stall();
    return D_dataHazard || (D_mdUse && (E_mdStart || m_rem > 0));
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_rem = 0; m_err = 1'b0; m_cnt = 32'd0;
    end else if (!freeze) begin
      if (m_stall()) m_cnt = m_cnt + 32'd1;
      if (m_rem > 0) begin
        if (E_mdStart) m_err = 1'b1;
        m_rem = m_rem - 1;
      end else if (E_mdStart) begin
        m_rem = E_mdIsDiv ? 10 : 5;
      end
    end
  end

  always @(negedge clk) begin
    logic e_run, e_st, e_busy, e_done;
    e_run  = !reset && !freeze;
    e_st   = e_run && m_stall();
    e_busy = !reset && (m_rem > 0);
    e_done = e_run && (m_rem == 1);
    chk("F_pcEn",   F_pcEn,   reset || (e_run && !e_st));
    chk("D_regEn",  D_regEn,  reset || (e_run && !e_st));
    chk("E_regEn",  E_regEn,  reset || e_run);
    chk("M_regEn",  M_regEn,  reset || e_run);
    chk("W_regEn",  W_regEn,  reset || e_run);
    chk("E_flush",  E_flush,  e_st);
    chk("E_mdBusy", E_mdBusy, e_busy);
    chk("E_mdDone", E_mdDone, e_done);
    chk("mdOverlapErr", mdOverlapErr, m_err);
    chk("stallCnt", stallCnt, m_cnt);
    if (E_mdBusy) busy_seen++;
    if (E_mdDone) done_seen++;
  end

  // One cycle of inputs: applied just after an edge, held until the next.
  task automatic cyc(input logic hz, input logic use_, input logic st,
                     input logic dv, input logic fz, input logic rs);
    D_dataHazard = hz; D_mdUse = use_; E_mdStart = st;
    E_mdIsDiv = dv; freeze = fz; reset = rs;
    @(posedge clk); #1;
  endtask

  int b0, d0;
  logic [31:0] s0;

  initial begin
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("reset_stallCnt", stallCnt, 32'd0);
    chk("reset_pcEn", {31'd0, F_pcEn}, 32'd1);

    // mult with an MD-use instruction waiting in D
    b0 = busy_seen; d0 = done_seen; s0 = stallCnt;
    cyc(0, 1, 1, 0, 0, 0);
    for (int i = 1; i <= 5; i++) cyc(0, 1, 0, 0, 0, 0);
    #4;
    chk("mult_release_pcEn", {31'd0, F_pcEn}, 32'd1);
    cyc(0, 1, 0, 0, 0, 0);
    chk("mult_stalls", stallCnt - s0, 32'd6);
    chk("mult_busy_cycles", busy_seen - b0, 5);
    chk("mult_done_pulses", done_seen - d0, 1);

    // div with a 3-cycle freeze mid-busy
    b0 = busy_seen; d0 = done_seen; s0 = stallCnt;
    cyc(0, 1, 1, 1, 0, 0);
    for (int i = 1; i <= 14; i++) cyc(0, 1, 0, 0, (i >= 4 && i <= 6), 0);
    chk("div_busy_cycles", busy_seen - b0, 13);
    chk("div_done_pulses", done_seen - d0, 1);
    chk("div_stalls", stallCnt - s0, 32'd11);

    // pure RAW hazard, MD idle
    b0 = busy_seen; s0 = stallCnt;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("raw_stalls", stallCnt - s0, 32'd2);
    chk("raw_busy", busy_seen - b0, 0);

    // overlapping start at cnt=3 (cycle 3 of a mult)
    b0 = busy_seen; d0 = done_seen;
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    for (int i = 4; i <= 8; i++) cyc(0, 0, 0, 0, 0, 0);
    chk("ovl_busy_cycles", busy_seen - b0, 5);
    chk("ovl_done_pulses", done_seen - d0, 1);
    chk("ovl_err", {31'd0, mdOverlapErr}, 32'd1);

    // reset in the middle of a div
    d0 = done_seen;
    cyc(0, 1, 1, 1, 0, 0);
    for (int i = 1; i <= 3; i++) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_busy", {31'd0, E_mdBusy}, 32'd0);
    chk("rst_err", {31'd0, mdOverlapErr}, 32'd0);
    chk("rst_stallCnt", stallCnt, 32'd0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0, 0, 0);
    chk("rst_no_done", done_seen - d0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
